// File: rtl/fp_pkg.sv
// Shared floating-point format definitions used by the operand sorter and the adder.
// Field layout of a word: [W-1] sign, [W-2:MAN_W] exponent, [MAN_W-1:0] stored mantissa.
package fp_pkg;

  localparam int EXP_W = 4;
  localparam int MAN_W = 7;
  localparam int W     = 1 + EXP_W + MAN_W;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_t;

  function automatic int word_w(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

endpackage

// File: rtl/fp_operand_sorter_if.sv
// Handshake bundle between the operand source, the sorter and the downstream adder.
interface fp_operand_sorter_if #(
  parameter int EXP_W = fp_pkg::EXP_W,
  parameter int MAN_W = fp_pkg::MAN_W
);

  localparam int W = fp_pkg::word_w(EXP_W, MAN_W);

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_x;
  logic [W-1:0]     in_y;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_a;
  logic [W-1:0]     out_b;
  logic [EXP_W-1:0] out_k;
  logic             out_swapped;
  logic             out_b_negl;
  logic             out_eff_sub;

  modport slave (
    input  in_valid, in_x, in_y, out_ready,
    output in_ready, out_valid, out_a, out_b, out_k,
           out_swapped, out_b_negl, out_eff_sub
  );

  modport master (
    output in_valid, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_k,
           out_swapped, out_b_negl, out_eff_sub
  );

endinterface

// File: rtl/fp_mag_compare.sv
// Combinational magnitude compare / swap / exponent difference for an operand pair.
// Sign is ignored for ordering; ties keep x as the larger operand.
module fp_mag_compare #(
  parameter int EXP_W = fp_pkg::EXP_W,
  parameter int MAN_W = fp_pkg::MAN_W
) (
  input  logic [EXP_W+MAN_W:0]   x,
  input  logic [EXP_W+MAN_W:0]   y,
  output logic [EXP_W+MAN_W:0]   a,
  output logic [EXP_W+MAN_W:0]   b,
  output logic [EXP_W-1:0]       k,
  output logic                   swapped,
  output logic                   b_negl,
  output logic                   eff_sub
);

  localparam int               MAG_W      = EXP_W + MAN_W;
  localparam logic [EXP_W:0]   NEGL_LIMIT = (EXP_W+1)'(MAN_W);

  logic [MAG_W-1:0] mag_x;
  logic [MAG_W-1:0] mag_y;
  logic [EXP_W-1:0] exp_a;
  logic [EXP_W-1:0] exp_b;
  logic             swap;

  assign mag_x = x[MAG_W-1:0];
  assign mag_y = y[MAG_W-1:0];
  assign swap  = mag_y > mag_x;

  assign a = swap ? y : x;
  assign b = swap ? x : y;

  assign exp_a = a[MAG_W-1:MAN_W];
  assign exp_b = b[MAG_W-1:MAN_W];

  // a >= b in magnitude, so the exponent difference never wraps.
  assign k       = exp_a - exp_b;
  assign b_negl  = {1'b0, k} > NEGL_LIMIT;
  assign eff_sub = x[MAG_W] ^ y[MAG_W];
  assign swapped = swap;

endmodule

// File: rtl/fp_operand_sorter.sv
// Sorts an operand pair by magnitude ahead of the adder, behind a 2-entry skid buffer.
// state      | meaning
// SKID_EMPTY | no pair held, outputs invalid
// SKID_ONE   | one pair in main register, presented on outputs
// SKID_FULL  | main presented, next pair parked in skid, input stalled
module fp_operand_sorter #(
  parameter int EXP_W = fp_pkg::EXP_W,
  parameter int MAN_W = fp_pkg::MAN_W
) (
  input  logic               clk,
  input  logic               rst,
  fp_operand_sorter_if.slave bus
);

  import fp_pkg::*;

  localparam int W      = word_w(EXP_W, MAN_W);
  localparam int PAIR_W = 2*W + EXP_W + 3;

  logic [W-1:0]      cmp_a;
  logic [W-1:0]      cmp_b;
  logic [EXP_W-1:0]  cmp_k;
  logic              cmp_swapped;
  logic              cmp_b_negl;
  logic              cmp_eff_sub;

  logic [PAIR_W-1:0] cmp_pair;
  logic [PAIR_W-1:0] main_q;
  logic [PAIR_W-1:0] skid_q;

  skid_state_t       state_q;
  skid_state_t       state_nxt;

  logic              push;
  logic              pop;
  logic              in_ready_int;
  logic              out_valid_int;
  logic              load_main_new;
  logic              load_main_skid;
  logic              load_skid;

  fp_mag_compare #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_mag_compare (
    .x       (bus.in_x),
    .y       (bus.in_y),
    .a       (cmp_a),
    .b       (cmp_b),
    .k       (cmp_k),
    .swapped (cmp_swapped),
    .b_negl  (cmp_b_negl),
    .eff_sub (cmp_eff_sub)
  );

  assign cmp_pair = {cmp_a, cmp_b, cmp_k, cmp_swapped, cmp_b_negl, cmp_eff_sub};

  // Handshake depends only on registered state, so out_ready never reaches in_ready.
  assign in_ready_int  = (state_q != SKID_FULL);
  assign out_valid_int = (state_q != SKID_EMPTY);

  assign push = bus.in_valid && in_ready_int;
  assign pop  = out_valid_int && bus.out_ready;

  always_comb begin
    state_nxt      = state_q;
    load_main_new  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      SKID_EMPTY: begin
        if (push) begin
          state_nxt     = SKID_ONE;
          load_main_new = 1'b1;
        end
      end
      SKID_ONE: begin
        if (push && pop) begin
          load_main_new = 1'b1;
        end else if (push) begin
          state_nxt = SKID_FULL;
          load_skid = 1'b1;
        end else if (pop) begin
          state_nxt = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (pop) begin
          state_nxt      = SKID_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_nxt = SKID_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SKID_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_nxt;
      if (load_main_new) begin
        main_q <= cmp_pair;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= cmp_pair;
      end
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_int;
  assign {bus.out_a, bus.out_b, bus.out_k,
          bus.out_swapped, bus.out_b_negl, bus.out_eff_sub} = main_q;

endmodule

// File: tb/tb_fp_operand_sorter.sv
// Directed bench for fp_operand_sorter: vector table streamed back-to-back, then
// hand-written backpressure and mid-operation reset sequences.
module tb_fp_operand_sorter;

  logic clk;
  logic rst;

  int checks;
  int failures;

  typedef struct {
    logic [11:0] x;
    logic [11:0] y;
    logic [11:0] a;
    logic [11:0] b;
    logic [3:0]  k;
    logic        sw;
    logic        negl;
    logic        es;
  } vec_t;

  vec_t vecs [9];

  fp_operand_sorter_if #(.EXP_W(4), .MAN_W(7)) bus ();

  fp_operand_sorter #(.EXP_W(4), .MAN_W(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic chk_pair(input string tag, input vec_t v);
    chk({tag, " out_valid"},   32'(bus.out_valid),   32'(1'b1));
    chk({tag, " out_a"},       32'(bus.out_a),       32'(v.a));
    chk({tag, " out_b"},       32'(bus.out_b),       32'(v.b));
    chk({tag, " out_k"},       32'(bus.out_k),       32'(v.k));
    chk({tag, " out_swapped"}, 32'(bus.out_swapped), 32'(v.sw));
    chk({tag, " out_b_negl"},  32'(bus.out_b_negl),  32'(v.negl));
    chk({tag, " out_eff_sub"}, 32'(bus.out_eff_sub), 32'(v.es));
  endtask

  task automatic drive(input logic valid, input logic [11:0] x, input logic [11:0] y);
    bus.in_valid = valid;
    bus.in_x     = x;
    bus.in_y     = y;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //          x       y       a       b       k     sw    negl  es
    vecs[0] = '{12'h480, 12'h300, 12'h480, 12'h300, 4'd3,  1'b0, 1'b0, 1'b0};
    vecs[1] = '{12'h100, 12'h3A5, 12'h3A5, 12'h100, 4'd5,  1'b1, 1'b0, 1'b0};
    vecs[2] = '{12'h080, 12'h780, 12'h780, 12'h080, 4'd14, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{12'h2AA, 12'hAAA, 12'h2AA, 12'hAAA, 4'd0,  1'b0, 1'b0, 1'b1};
    vecs[4] = '{12'h400, 12'h080, 12'h400, 12'h080, 4'd7,  1'b0, 1'b0, 1'b0};
    vecs[5] = '{12'h080, 12'hC80, 12'hC80, 12'h080, 4'd8,  1'b1, 1'b1, 1'b1};
    vecs[6] = '{12'h305, 12'h30A, 12'h30A, 12'h305, 4'd0,  1'b1, 1'b0, 1'b0};
    vecs[7] = '{12'hB00, 12'h8FF, 12'hB00, 12'h8FF, 4'd5,  1'b0, 1'b0, 1'b0};
    vecs[8] = '{12'h000, 12'h000, 12'h000, 12'h000, 4'd0,  1'b0, 1'b0, 1'b0};

    rst           = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b0, 12'h000, 12'h000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    chk("reset out_valid",   32'(bus.out_valid),   32'(1'b0));
    chk("reset in_ready",    32'(bus.in_ready),    32'(1'b1));
    chk("reset out_a",       32'(bus.out_a),       32'(0));
    chk("reset out_b",       32'(bus.out_b),       32'(0));
    chk("reset out_k",       32'(bus.out_k),       32'(0));
    chk("reset out_swapped", 32'(bus.out_swapped), 32'(0));
    chk("reset out_b_negl",  32'(bus.out_b_negl),  32'(0));
    chk("reset out_eff_sub", 32'(bus.out_eff_sub), 32'(0));

    // Idle input must not create a pair.
    drive(1'b0, 12'h480, 12'h300);
    @(negedge clk);
    chk("idle out_valid", 32'(bus.out_valid), 32'(1'b0));

    // Stream the table back-to-back: each pair must appear exactly one cycle later.
    drive(1'b1, vecs[0].x, vecs[0].y);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk_pair($sformatf("vec%0d", i), vecs[i]);
      chk($sformatf("vec%0d in_ready", i), 32'(bus.in_ready), 32'(1'b1));
      if (i + 1 < 9) drive(1'b1, vecs[i+1].x, vecs[i+1].y);
      else           drive(1'b0, 12'h000, 12'h000);
    end
    @(negedge clk);
    chk("drain out_valid", 32'(bus.out_valid), 32'(1'b0));

    // Backpressure: three pushes with out_ready low.
    bus.out_ready = 1'b0;
    drive(1'b1, vecs[0].x, vecs[0].y);
    @(negedge clk);
    chk("bp after push1 in_ready", 32'(bus.in_ready), 32'(1'b1));
    drive(1'b1, vecs[1].x, vecs[1].y);
    @(negedge clk);
    chk("bp after push2 in_ready", 32'(bus.in_ready), 32'(1'b0));
    drive(1'b1, vecs[3].x, vecs[3].y);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_pair($sformatf("bp hold%0d", i), vecs[0]);
      chk($sformatf("bp hold%0d in_ready", i), 32'(bus.in_ready), 32'(1'b0));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk_pair("bp pair2", vecs[1]);
    chk("bp pair2 in_ready", 32'(bus.in_ready), 32'(1'b1));
    @(negedge clk);
    chk_pair("bp pair3", vecs[3]);
    drive(1'b0, 12'h000, 12'h000);
    @(negedge clk);
    chk("bp drain out_valid", 32'(bus.out_valid), 32'(1'b0));

    // Fill to FULL, then reset with a pending push that must be ignored.
    bus.out_ready = 1'b0;
    drive(1'b1, vecs[4].x, vecs[4].y);
    @(negedge clk);
    drive(1'b1, vecs[5].x, vecs[5].y);
    @(negedge clk);
    chk("full in_ready", 32'(bus.in_ready), 32'(1'b0));
    rst           = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, vecs[6].x, vecs[6].y);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 12'h000, 12'h000);
    chk("rst mid out_valid", 32'(bus.out_valid), 32'(1'b0));
    chk("rst mid in_ready",  32'(bus.in_ready),  32'(1'b1));
    chk("rst mid out_a",     32'(bus.out_a),     32'(0));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rst stale%0d out_valid", i), 32'(bus.out_valid), 32'(1'b0));
    end

    // Traffic resumes normally after the flush.
    drive(1'b1, vecs[2].x, vecs[2].y);
    @(negedge clk);
    chk_pair("post rst", vecs[2]);
    drive(1'b0, 12'h000, 12'h000);
    @(negedge clk);
    chk("post rst drain", 32'(bus.out_valid), 32'(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
